vending_panel_arbiter: RTL and testbench
========================================

# vending_panel_arbiter

Shares one `vendingMachine` core between two customer front panels. Each panel's purchase request is granted round-robin and issued to the core as a one-cycle input beat. The arbiter waits for the core's `SERVICE_OFF` cycle, captures change and item, and returns them to the winning panel. A watchdog resets the core and refunds the panel if a transaction stalls, which can happen in the core's NTD_1-shortage refund loop.

## Interface
- `TIMEOUT`, default 12: max cycles in WAIT before recovery; legal range 1..15 (4-bit counter).
- `RST_CYC`, default 2: cycles `core_rst_n` is held low in INIT/RECOVER.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-panel request; held with its payload stable until `req_ack[i]`.
- `req_coin5`  in  2  per-panel NTD_5 coin present.
- `req_coin1`  in  2  per-panel NTD_1 coin present.
- `req_item`  in  2  per-panel item (1 = ITEM_A, 0 = none).
- `req_ack`  out  2  one-cycle pulse: request latched.
- `resp_valid`  out  2  one-cycle pulse: response fields valid for panel i.
- `resp_coin5`  out  1  NTD_5 change returned.
- `resp_coin1`  out  1  NTD_1 change returned.
- `resp_item`  out  1  item delivered.
- `resp_err`  out  1  transaction aborted by watchdog.
- `busy`  out  1  high in every state except IDLE.
- `core_coinInNTD_5`  out  1  to core `coinInNTD_5`.
- `core_coinInNTD_1`  out  1  to core `coinInNTD_1`.
- `core_itemTypeIn`  out  1  to core `itemTypeIn`.
- `core_rst_n`  out  1  to core `reset`; active-low, synchronous in core.
- `core_coinOutNTD_5`  in  1  from core.
- `core_coinOutNTD_1`  in  1  from core.
- `core_itemTypeOut`  in  1  from core.
- `core_serviceTypeOut`  in  2  from core: 00 OFF, 01 ON, 10 BUSY.

## Operation
- All outputs are registered.
- Reset values: all outputs 0, except `busy`=1 and `core_rst_n`=0. State = INIT, rr pointer = 0, counters = 0.
- INIT: hold `core_rst_n`=0 for RST_CYC cycles after reset release, then go to IDLE (`core_rst_n`=1).
- IDLE: act only if `core_serviceTypeOut`==ON and `req` != 0.
  - Winner: panel rr if `req[rr]`, else the other panel.
  - Latch winner id and its coin5/coin1/item.
  - If latched item=0: go to RESP, echo the coins as refund, `resp_item`=0, `resp_err`=0; the core is not touched.
  - Otherwise: go to ISSUE.
- ISSUE (1 cycle): pulse `req_ack[id]`; drive the core inputs with the latched values; go to WAIT with the watchdog cleared.
- Core inputs are 0 in every state other than ISSUE. Item 0 means the core ignores the beat.
- For item=0 requests, `req_ack[id]` pulses in the RESP cycle.
- WAIT: watchdog increments each cycle.
  - `core_serviceTypeOut`==OFF: capture `core_coinOutNTD_5`, `core_coinOutNTD_1`, `core_itemTypeOut`; go to RESP.
  - Watchdog reaches TIMEOUT first: go to RECOVER.
  - OFF on the same cycle the watchdog reaches TIMEOUT: OFF wins.
- RECOVER: hold `core_rst_n`=0 for RST_CYC cycles, then go to RESP with `resp_err`=1, `resp_item`=0 and the latched coins echoed as refund.
- RESP (1 cycle): pulse `resp_valid[id]` with the response fields; set rr = ~id; go to IDLE.
- Response fields hold their last values until the next RESP.
- Round-robin: with both panels requesting continuously, grants alternate 0,1,0,1…
- A request deasserted before it is granted is simply not served.
- Requests arriving while `busy` wait; they are sampled only in IDLE.
- IDLE with core not ON (for example, the ON-after-OFF transition): no grant.
- Reset mid-operation: immediate return to INIT; the in-flight transaction is dropped with no `resp_valid`. The core is re-reset via INIT.

## Timing
- Issue latency: request present in IDLE cycle t (core ON) → `req_ack` and core inputs high in cycle t+1.
- Exact change (item A, coin5+coin1, value 3): core BUSY t+2..t+4, OFF t+5, `resp_valid` at t+6.
- Each dispensed coin adds 1 cycle of BUSY.
- Item-0 request: `resp_valid` and `req_ack` at t+1.
- Timeout path: `resp_valid` at t+1+TIMEOUT+RST_CYC+1.
- Minimum back-to-back spacing: the next grant is no earlier than the cycle after RESP.

## Test plan
- Reset release, panel0 requests item 1, coin5=1, coin1=1 → `core_rst_n` low 2 cycles; `req_ack`=01; `resp_valid`=01 six cycles after the grant cycle; coin5=0, coin1=0, item=1, err=0.
- Panel1 requests item 1, coin5=1, coin1=0 (value 2 < 3) → `resp_valid`=10; coin5=1, coin1=0, item=0 (refund).
- Both panels request continuously, 4 transactions → ack order 01,10,01,10; no overlap of `busy` periods.
- Hold `core_serviceTypeOut`=BUSY (core stubbed), TIMEOUT=12 → `core_rst_n` low 2 cycles; `resp_err`=1, item=0, coins echoed, at grant+1+12+2+1.
- Panel0 requests item 0, coin1=1 → `req_ack` and `resp_valid` together one cycle later, coin1=1; the core sees no item.
- Assert `reset` while in WAIT → outputs return to reset values immediately; no `resp_valid`; after release, the INIT sequence runs and a repeated request completes normally.

Source files
------------

// File: rtl/vending_panel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vending_panel_arbiter
// Purpose  : Round-robin sharing of one vendingMachine core between two
//            customer panels, with a watchdog that re-resets a stalled core
//            and refunds the panel that was being served.
// Revision : 1.0 - initial release
// ============================================================================
module vending_panel_arbiter #(
    parameter int TIMEOUT = 12,   // WAIT cycles before recovery, 1..15
    parameter int RST_CYC = 2     // core reset length in INIT / RECOVER
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] req_coin5,
    input  logic [1:0] req_coin1,
    input  logic [1:0] req_item,
    output logic [1:0] req_ack,
    output logic [1:0] resp_valid,
    output logic       resp_coin5,
    output logic       resp_coin1,
    output logic       resp_item,
    output logic       resp_err,
    output logic       busy,
    output logic       core_coinInNTD_5,
    output logic       core_coinInNTD_1,
    output logic       core_itemTypeIn,
    output logic       core_rst_n,
    input  logic       core_coinOutNTD_5,
    input  logic       core_coinOutNTD_1,
    input  logic       core_itemTypeOut,
    input  logic [1:0] core_serviceTypeOut
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_RECOVER = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    localparam logic [1:0] c_svcOff      = 2'b00;
    localparam logic [1:0] c_svcOn       = 2'b01;
    localparam logic [3:0] c_timeoutLast = 4'(TIMEOUT - 1);
    localparam logic [3:0] c_rstLast     = 4'(RST_CYC - 1);

    state_t     r_state, w_stateNext;
    logic [3:0] r_cnt, w_cntNext;       // reset-length counter and watchdog share it
    logic       r_rr, w_rrNext;
    logic       r_id, w_idNext;
    logic       r_coin5, w_coin5Next;
    logic       r_coin1, w_coin1Next;
    logic       w_winner;

    logic [1:0] w_reqAck, w_respValid;
    logic       w_respCoin5, w_respCoin1, w_respItem, w_respErr;
    logic       w_busy, w_coreCoin5, w_coreCoin1, w_coreItem, w_coreRstN;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_rrNext    = r_rr;
        w_idNext    = r_id;
        w_coin5Next = r_coin5;
        w_coin1Next = r_coin1;
        w_winner    = req[r_rr] ? r_rr : ~r_rr;
        w_reqAck    = 2'b00;
        w_respValid = 2'b00;
        w_respCoin5 = resp_coin5;
        w_respCoin1 = resp_coin1;
        w_respItem  = resp_item;
        w_respErr   = resp_err;
        w_coreCoin5 = 1'b0;
        w_coreCoin1 = 1'b0;
        w_coreItem  = 1'b0;
        w_coreRstN  = 1'b1;

        case (r_state)
            S_INIT: begin
                w_coreRstN = 1'b0;
                w_cntNext  = r_cnt + 4'd1;
                if (r_cnt == c_rstLast) begin
                    w_stateNext = S_IDLE;
                    w_cntNext   = 4'd0;
                    w_coreRstN  = 1'b1;
                end
            end
            S_IDLE: begin
                if ((core_serviceTypeOut == c_svcOn) && (req != 2'b00)) begin
                    w_idNext    = w_winner;
                    w_coin5Next = req_coin5[w_winner];
                    w_coin1Next = req_coin1[w_winner];
                    w_reqAck    = w_winner ? 2'b10 : 2'b01;
                    if (!req_item[w_winner]) begin
                        // Nothing to buy: refund locally, the core never sees it.
                        w_stateNext = S_RESP;
                        w_respValid = w_winner ? 2'b10 : 2'b01;
                        w_respCoin5 = req_coin5[w_winner];
                        w_respCoin1 = req_coin1[w_winner];
                        w_respItem  = 1'b0;
                        w_respErr   = 1'b0;
                        w_rrNext    = ~w_winner;
                    end else begin
                        w_stateNext = S_ISSUE;
                        w_coreCoin5 = req_coin5[w_winner];
                        w_coreCoin1 = req_coin1[w_winner];
                        w_coreItem  = req_item[w_winner];
                    end
                end
            end
            S_ISSUE: begin
                w_stateNext = S_WAIT;
                w_cntNext   = 4'd0;
            end
            S_WAIT: begin
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (core_serviceTypeOut == c_svcOff) begin
                    w_stateNext = S_RESP;
                    w_respValid = r_id ? 2'b10 : 2'b01;
                    w_respCoin5 = core_coinOutNTD_5;
                    w_respCoin1 = core_coinOutNTD_1;
                    w_respItem  = core_itemTypeOut;
                    w_respErr   = 1'b0;
                    w_rrNext    = ~r_id;
                end else if (r_cnt == c_timeoutLast) begin
                    w_stateNext = S_RECOVER;
                    w_cntNext   = 4'd0;
                    w_coreRstN  = 1'b0;
                end else begin
                    w_cntNext = r_cnt + 4'd1;
                end
            end
            S_RECOVER: begin
                w_coreRstN = 1'b0;
                w_cntNext  = r_cnt + 4'd1;
                if (r_cnt == c_rstLast) begin
                    w_stateNext = S_RESP;
                    w_cntNext   = 4'd0;
                    w_coreRstN  = 1'b1;
                    w_respValid = r_id ? 2'b10 : 2'b01;
                    w_respCoin5 = r_coin5;
                    w_respCoin1 = r_coin1;
                    w_respItem  = 1'b0;
                    w_respErr   = 1'b1;
                    w_rrNext    = ~r_id;
                end
            end
            S_RESP: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_INIT;
                w_cntNext   = 4'd0;
            end
        endcase

        w_busy = (w_stateNext != S_IDLE);
    end

    // State and registered outputs; reset forces INIT with the core held in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_INIT;
            r_cnt            <= 4'd0;
            r_rr             <= 1'b0;
            r_id             <= 1'b0;
            r_coin5          <= 1'b0;
            r_coin1          <= 1'b0;
            req_ack          <= 2'b00;
            resp_valid       <= 2'b00;
            resp_coin5       <= 1'b0;
            resp_coin1       <= 1'b0;
            resp_item        <= 1'b0;
            resp_err         <= 1'b0;
            busy             <= 1'b1;
            core_coinInNTD_5 <= 1'b0;
            core_coinInNTD_1 <= 1'b0;
            core_itemTypeIn  <= 1'b0;
            core_rst_n       <= 1'b0;
        end else begin
            r_state          <= w_stateNext;
            r_cnt            <= w_cntNext;
            r_rr             <= w_rrNext;
            r_id             <= w_idNext;
            r_coin5          <= w_coin5Next;
            r_coin1          <= w_coin1Next;
            req_ack          <= w_reqAck;
            resp_valid       <= w_respValid;
            resp_coin5       <= w_respCoin5;
            resp_coin1       <= w_respCoin1;
            resp_item        <= w_respItem;
            resp_err         <= w_respErr;
            busy             <= w_busy;
            core_coinInNTD_5 <= w_coreCoin5;
            core_coinInNTD_1 <= w_coreCoin1;
            core_itemTypeIn  <= w_coreItem;
            core_rst_n       <= w_coreRstN;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vending_panel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_panel_arbiter
// Purpose  : Self-checking bench for vending_panel_arbiter with a behavioural
//            vendingMachine stand-in and a value-based outcome model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vending_panel_arbiter;

    localparam int TIMEOUT = 12;
    localparam int RST_CYC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00, req_coin5 = 2'b00, req_coin1 = 2'b00, req_item = 2'b00;
    logic [1:0] req_ack, resp_valid;
    logic       resp_coin5, resp_coin1, resp_item, resp_err, busy;
    logic       core_coinInNTD_5, core_coinInNTD_1, core_itemTypeIn, core_rst_n;
    logic       core_coinOutNTD_5 = 1'b0, core_coinOutNTD_1 = 1'b0, core_itemTypeOut = 1'b0;
    logic [1:0] core_serviceTypeOut = 2'b01;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic expRr = 1'b0;
    logic stall = 1'b0;

    vending_panel_arbiter #(.TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)) dut (
        .clk(clk), .reset(reset),
        .req(req), .req_coin5(req_coin5), .req_coin1(req_coin1), .req_item(req_item),
        .req_ack(req_ack), .resp_valid(resp_valid),
        .resp_coin5(resp_coin5), .resp_coin1(resp_coin1), .resp_item(resp_item),
        .resp_err(resp_err), .busy(busy),
        .core_coinInNTD_5(core_coinInNTD_5), .core_coinInNTD_1(core_coinInNTD_1),
        .core_itemTypeIn(core_itemTypeIn), .core_rst_n(core_rst_n),
        .core_coinOutNTD_5(core_coinOutNTD_5), .core_coinOutNTD_1(core_coinOutNTD_1),
        .core_itemTypeOut(core_itemTypeOut), .core_serviceTypeOut(core_serviceTypeOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in: price 3 (NTD_5 worth 2, NTD_1 worth 1), BUSY for 3 cycles
    // plus one per refunded coin, then one OFF cycle carrying the result.
    logic [3:0] stubCnt = 4'd0;
    logic       pC5 = 1'b0, pC1 = 1'b0, pIt = 1'b0;
    always @(posedge clk) begin
        if (!core_rst_n) begin
            core_serviceTypeOut <= 2'b01;
            core_coinOutNTD_5   <= 1'b0;
            core_coinOutNTD_1   <= 1'b0;
            core_itemTypeOut    <= 1'b0;
            stubCnt             <= 4'd0;
        end else if (core_serviceTypeOut == 2'b01) begin
            if (core_itemTypeIn) begin
                core_serviceTypeOut <= 2'b10;
                if (2 * core_coinInNTD_5 + core_coinInNTD_1 >= 3) begin
                    pC5 <= 1'b0; pC1 <= 1'b0; pIt <= 1'b1; stubCnt <= 4'd2;
                end else begin
                    pC5 <= core_coinInNTD_5; pC1 <= core_coinInNTD_1; pIt <= 1'b0;
                    stubCnt <= 4'(2 + core_coinInNTD_5 + core_coinInNTD_1);
                end
            end
        end else if (core_serviceTypeOut == 2'b10) begin
            if (!stall) begin
                if (stubCnt == 4'd0) begin
                    core_serviceTypeOut <= 2'b00;
                    core_coinOutNTD_5   <= pC5;
                    core_coinOutNTD_1   <= pC1;
                    core_itemTypeOut    <= pIt;
                end else begin
                    stubCnt <= stubCnt - 4'd1;
                end
            end
        end else begin
            core_serviceTypeOut <= 2'b01;
            core_coinOutNTD_5   <= 1'b0;
            core_coinOutNTD_1   <= 1'b0;
            core_itemTypeOut    <= 1'b0;
        end
    end

    // Outcome model: latency from the grant cycle and {coin5,coin1,item,err}.
    function automatic void model(input logic c5, input logic c1, input logic it,
                                  output int lat, output logic [3:0] f);
        int value;
        value = 2 * int'(c5) + int'(c1);
        if (!it) begin
            lat = 1;
            f   = {c5, c1, 1'b0, 1'b0};
        end else if (value >= 3) begin
            lat = 6;
            f   = 4'b0010;
        end else begin
            lat = 6 + int'(c5) + int'(c1);
            f   = {c5, c1, 1'b0, 1'b0};
        end
    endfunction

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            if (!busy && core_serviceTypeOut == 2'b01) break;
            @(negedge clk);
        end
    endtask

    // Issue one request on panel p and observe it through to its response.
    task automatic do_req(input int p, input logic c5, input logic c1, input logic it,
                          output int ackLat, output int respLat, output logic [3:0] f,
                          output logic [1:0] rv, output logic [2:0] beat,
                          output int rstLow, output logic sawItem);
        int start;
        ackLat = -1; respLat = -1; f = 4'b0000; rv = 2'b00; beat = 3'b000;
        rstLow = 0; sawItem = 1'b0;
        wait_idle();
        req[p] = 1'b1; req_coin5[p] = c5; req_coin1[p] = c1; req_item[p] = it;
        start = cyc;
        for (int n = 0; n < 64 && respLat < 0; n++) begin
            @(negedge clk);
            if (!core_rst_n) rstLow++;
            if (core_itemTypeIn) sawItem = 1'b1;
            if (req_ack[p] && ackLat < 0) begin
                ackLat = cyc - start;
                beat   = {core_coinInNTD_5, core_coinInNTD_1, core_itemTypeIn};
                req[p] = 1'b0;
            end
            if (resp_valid[p]) begin
                respLat = cyc - start;
                f  = {resp_coin5, resp_coin1, resp_item, resp_err};
                rv = resp_valid;
            end
        end
        req[p] = 1'b0;
        expRr = (p == 0);
    endtask

    task automatic test_reset();
        int lowCnt;
        repeat (3) @(negedge clk);
        checks++; if ({busy, core_rst_n} !== 2'b10) begin failures++;
            $display("FAIL reset_busy_rstn actual=%b required=10", {busy, core_rst_n}); end
        checks++; if ({req_ack, resp_valid, resp_coin5, resp_coin1, resp_item, resp_err} !== 8'h00) begin failures++;
            $display("FAIL reset_outputs actual=%h required=00", {req_ack, resp_valid, resp_coin5, resp_coin1, resp_item, resp_err}); end
        checks++; if ({core_coinInNTD_5, core_coinInNTD_1, core_itemTypeIn} !== 3'b000) begin failures++;
            $display("FAIL reset_core_inputs actual=%b required=000", {core_coinInNTD_5, core_coinInNTD_1, core_itemTypeIn}); end
        reset = 1'b0;
        lowCnt = 0;
        for (int n = 0; n < 20 && !core_rst_n; n++) begin lowCnt++; @(negedge clk); end
        checks++; if (lowCnt !== RST_CYC) begin failures++;
            $display("FAIL init_rst_len actual=%0d required=%0d", lowCnt, RST_CYC); end
        expRr = 1'b0;
    endtask

    task automatic test_exact_change();
        int a, r, rl, el; logic [3:0] f, ef; logic [1:0] rv; logic [2:0] b; logic si;
        model(1'b1, 1'b1, 1'b1, el, ef);
        do_req(0, 1'b1, 1'b1, 1'b1, a, r, f, rv, b, rl, si);
        checks++; if (a !== 1) begin failures++; $display("FAIL exact_ack_lat actual=%0d required=1", a); end
        checks++; if (b !== 3'b111) begin failures++; $display("FAIL exact_core_beat actual=%b required=111", b); end
        checks++; if (r !== el) begin failures++; $display("FAIL exact_resp_lat actual=%0d required=%0d", r, el); end
        checks++; if (f !== ef) begin failures++; $display("FAIL exact_fields actual=%b required=%b", f, ef); end
        checks++; if (rv !== 2'b01) begin failures++; $display("FAIL exact_resp_valid actual=%b required=01", rv); end
        @(negedge clk);
        checks++; if ({resp_valid, resp_coin5, resp_coin1, resp_item, resp_err} !== {2'b00, ef}) begin failures++;
            $display("FAIL resp_hold actual=%b required=%b", {resp_valid, resp_coin5, resp_coin1, resp_item, resp_err}, {2'b00, ef}); end
    endtask

    task automatic test_refund();
        int a, r, rl, el; logic [3:0] f, ef; logic [1:0] rv; logic [2:0] b; logic si;
        model(1'b1, 1'b0, 1'b1, el, ef);
        do_req(1, 1'b1, 1'b0, 1'b1, a, r, f, rv, b, rl, si);
        checks++; if (r !== el) begin failures++; $display("FAIL refund_resp_lat actual=%0d required=%0d", r, el); end
        checks++; if (f !== ef) begin failures++; $display("FAIL refund_fields actual=%b required=%b", f, ef); end
        checks++; if (rv !== 2'b10) begin failures++; $display("FAIL refund_resp_valid actual=%b required=10", rv); end
    endtask

    task automatic test_item_zero();
        int a, r, rl, el; logic [3:0] f, ef; logic [1:0] rv; logic [2:0] b; logic si;
        model(1'b0, 1'b1, 1'b0, el, ef);
        do_req(0, 1'b0, 1'b1, 1'b0, a, r, f, rv, b, rl, si);
        checks++; if (a !== 1 || r !== el) begin failures++;
            $display("FAIL item0_lat actual=%0d/%0d required=1/%0d", a, r, el); end
        checks++; if (f !== ef) begin failures++; $display("FAIL item0_fields actual=%b required=%b", f, ef); end
        checks++; if (si !== 1'b0 || b !== 3'b000) begin failures++;
            $display("FAIL item0_core_touched actual=%b/%b required=0/000", si, b); end
    endtask

    task automatic test_random();
        int a, r, rl, el; logic [3:0] f, ef; logic [1:0] rv; logic [2:0] b; logic si;
        int p; logic c5, c1, it;
        for (int i = 0; i < 16; i++) begin
            p  = int'($urandom_range(0, 1));
            c5 = 1'($urandom_range(0, 1));
            c1 = 1'($urandom_range(0, 1));
            it = 1'($urandom_range(0, 1));
            model(c5, c1, it, el, ef);
            do_req(p, c5, c1, it, a, r, f, rv, b, rl, si);
            checks++; if (a !== 1 || r !== el) begin failures++;
                $display("FAIL rand_lat i=%0d actual=%0d/%0d required=1/%0d", i, a, r, el); end
            checks++; if (f !== ef || rv !== (p == 1 ? 2'b10 : 2'b01)) begin failures++;
                $display("FAIL rand_resp i=%0d actual=%b/%b required=%b panel=%0d", i, f, rv, ef, p); end
            checks++; if (si !== it) begin failures++;
                $display("FAIL rand_core_item i=%0d actual=%b required=%b", i, si, it); end
        end
    endtask

    task automatic test_round_robin();
        int order[$]; int resps, overlap; logic first;
        resps = 0; overlap = 0;
        wait_idle();
        first = expRr;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b1; req_coin5[p] = 1'($urandom_range(0, 1));
            req_coin1[p] = 1'($urandom_range(0, 1)); req_item[p] = 1'b1;
        end
        for (int n = 0; n < 200 && resps < 4; n++) begin
            @(negedge clk);
            if (req_ack != 2'b00) begin
                if (order.size() != resps) overlap++;
                order.push_back(req_ack == 2'b10 ? 1 : 0);
                if (order.size() == 4) req = 2'b00;
            end
            if (resp_valid != 2'b00) resps++;
        end
        req = 2'b00;
        checks++; if (order.size() !== 4 || resps !== 4) begin failures++;
            $display("FAIL rr_count actual=%0d/%0d required=4/4", order.size(), resps); end
        for (int i = 0; i < order.size(); i++) begin
            checks++; if (order[i] !== (int'(first) ^ (i & 1))) begin failures++;
                $display("FAIL rr_order i=%0d actual=%0d required=%0d", i, order[i], int'(first) ^ (i & 1)); end
        end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL rr_overlap actual=%0d required=0", overlap); end
    endtask

    task automatic test_timeout();
        int a, r, rl, el; logic [3:0] f; logic [1:0] rv; logic [2:0] b; logic si;
        int p; logic c5, c1;
        p = int'($urandom_range(0, 1));
        c5 = 1'($urandom_range(0, 1));
        c1 = 1'($urandom_range(0, 1));
        el = 1 + TIMEOUT + RST_CYC + 1;
        stall = 1'b1;
        do_req(p, c5, c1, 1'b1, a, r, f, rv, b, rl, si);
        stall = 1'b0;
        checks++; if (a !== 1 || r !== el) begin failures++;
            $display("FAIL tmo_lat actual=%0d/%0d required=1/%0d", a, r, el); end
        checks++; if (f !== {c5, c1, 1'b0, 1'b1}) begin failures++;
            $display("FAIL tmo_fields actual=%b required=%b", f, {c5, c1, 1'b0, 1'b1}); end
        checks++; if (rl !== RST_CYC) begin failures++; $display("FAIL tmo_rst_len actual=%0d required=%0d", rl, RST_CYC); end
    endtask

    task automatic test_reset_mid_wait();
        int a, r, rl, el, lowCnt, sawResp; logic [3:0] f, ef; logic [1:0] rv; logic [2:0] b; logic si;
        sawResp = 0;
        wait_idle();
        req[0] = 1'b1; req_coin5[0] = 1'b1; req_coin1[0] = 1'b1; req_item[0] = 1'b1;
        for (int n = 0; n < 10 && !req_ack[0]; n++) @(negedge clk);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy, core_rst_n, req_ack, resp_valid, resp_coin5, resp_coin1, resp_item, resp_err} !== 10'b10_0000_0000) begin failures++;
            $display("FAIL midreset_outputs actual=%b required=1000000000",
                     {busy, core_rst_n, req_ack, resp_valid, resp_coin5, resp_coin1, resp_item, resp_err}); end
        for (int n = 0; n < 3; n++) begin @(negedge clk); if (resp_valid != 2'b00) sawResp++; end
        reset = 1'b0;
        lowCnt = 0;
        for (int n = 0; n < 20 && !core_rst_n; n++) begin
            lowCnt++; if (resp_valid != 2'b00) sawResp++; @(negedge clk);
        end
        checks++; if (lowCnt !== RST_CYC) begin failures++; $display("FAIL midreset_init_len actual=%0d required=%0d", lowCnt, RST_CYC); end
        checks++; if (sawResp !== 0) begin failures++; $display("FAIL midreset_resp actual=%0d required=0", sawResp); end
        model(1'b1, 1'b1, 1'b1, el, ef);
        do_req(0, 1'b1, 1'b1, 1'b1, a, r, f, rv, b, rl, si);
        checks++; if (a !== 1 || r !== el || f !== ef) begin failures++;
            $display("FAIL midreset_retry actual=%0d/%0d/%b required=1/%0d/%b", a, r, f, el, ef); end
    endtask

    initial begin
        test_reset();
        test_exact_change();
        test_refund();
        test_item_zero();
        test_random();
        test_round_robin();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
